// File: rtl/ifu_pc_ir.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_ir
// Brief    : Instruction-fetch stage holding PC/IR, imem req/ack fetch with
//            timeout, next-PC selection for branch/jump, stall to controller.
// Revision : 1.0
// ============================================================================
module ifu_pc_ir #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  branch,
    input  logic [1:0]  jump,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        stall,
    output logic        fetch_err,
    output logic        align_err
);

    localparam int               c_CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CW-1:0]  c_TO_LAST = c_CW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       c_J_JR    = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic              r_fetch_err;
    logic              r_align_err;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_br_off;
    logic [31:0]       w_pc_next;
    logic              w_in_fetch;
    logic              w_timeout;
    logic              w_pc_upd;

    assign w_in_fetch = (r_state == S_FETCH);
    // Ack wins over timeout when both land in the same cycle.
    assign w_timeout  = w_in_fetch && !imem_ack && (r_cnt == c_TO_LAST);
    assign w_pc_upd   = (r_state == S_IDLE) && pc_wr && !ir_wr;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (jump == c_J_JR) begin
            w_pc_next = {rs_data[31:2], 2'b00};
        end else if (jump != 2'b00) begin
            w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
        end else if (branch != 2'b00) begin
            w_pc_next = r_pc + w_br_off;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ir_wr) begin
                    w_state_nxt = S_FETCH;
                    stall       = 1'b1;
                end
            end
            S_FETCH: begin
                stall = !imem_ack && !w_timeout;
                if (imem_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_fetch_err <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fetch) begin
                if (imem_ack) begin
                    r_ir  <= imem_rdata;
                    r_pc  <= w_pc_plus4;
                    r_cnt <= '0;
                end else if (w_timeout) begin
                    r_ir        <= 32'd0;
                    r_pc        <= w_pc_plus4;
                    r_fetch_err <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end else if (w_pc_upd) begin
                r_pc <= w_pc_next;
                if ((jump == c_J_JR) && (rs_data[1:0] != 2'b00)) begin
                    r_align_err <= 1'b1;
                end
            end
        end
    end

    assign imem_req  = w_in_fetch;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign ir        = r_ir;
    assign fetch_err = r_fetch_err;
    assign align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_ir.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_pc_ir
// Brief    : Directed self-checking bench for ifu_pc_ir with fetch scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ifu_pc_ir;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr;
    logic        ir_wr;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic        stall;
    logic        fetch_err;
    logic        align_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    ifu_pc_ir #(
        .RESET_PC    (32'h0000_3000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .branch     (branch),
        .jump       (jump),
        .rs_data    (rs_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ir         (ir),
        .stall      (stall),
        .fetch_err  (fetch_err),
        .align_err  (align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a fetch; the expected IR/PC go on the scoreboard at request time.
    task automatic fetch(input logic [31:0] rdata, input int waits, input logic [31:0] exp_pc);
        exp_ir_q.push_back(rdata);
        exp_pc_q.push_back(exp_pc);
        ir_wr = 1'b1;
        #1;
        check("stall_on_irwr", 32'(stall), 32'd1);
        tick();
        ir_wr = 1'b0;
        #1;
        check("imem_addr", imem_addr, exp_pc - 32'd4);
        for (int i = 0; i < waits; i++) begin
            check("req_wait", 32'(imem_req), 32'd1);
            check("stall_wait", 32'(stall), 32'd1);
            tick();
        end
        imem_rdata = rdata;
        imem_ack   = 1'b1;
        #1;
        check("stall_on_ack", 32'(stall), 32'd0);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("req_after_ack", 32'(imem_req), 32'd0);
        check("fetch_ir", ir, exp_ir_q.pop_front());
        check("fetch_pc", pc, exp_pc_q.pop_front());
    endtask

    task automatic pcwr(input string tag, input logic [1:0] j, input logic [1:0] b,
                        input logic [31:0] rs, input logic [31:0] exp_pc);
        pc_wr   = 1'b1;
        jump    = j;
        branch  = b;
        rs_data = rs;
        tick();
        pc_wr   = 1'b0;
        jump    = 2'b00;
        branch  = 2'b00;
        rs_data = 32'd0;
        check(tag, pc, exp_pc);
    endtask

    initial begin
        int cyc;
        rst        = 1'b0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        branch     = 2'b00;
        jump       = 2'b00;
        rs_data    = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_ir", ir, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        rst = 1'b1;
        tick();

        // Ack while idle is ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("idle_ack_ir", ir, 32'd0);
        check("idle_ack_pc", pc, 32'h0000_3000);

        // Fetch with 3 wait cycles: stall high for 4 cycles in total
        fetch(32'h8C08_0004, 3, 32'h0000_3004);
        check("pc_plus4", pc_plus4, 32'h0000_3008);

        pcwr("beq_imm4", 2'b00, 2'b01, 32'd0, 32'h0000_3014);
        pcwr("seq_pc4", 2'b00, 2'b00, 32'd0, 32'h0000_3018);
        pcwr("jr_3000", 2'b11, 2'b00, 32'h0000_3000, 32'h0000_3000);
        check("align_clean", 32'(align_err), 32'd0);

        fetch(32'h1000_FFFF, 0, 32'h0000_3004);
        pcwr("beq_back", 2'b00, 2'b01, 32'd0, 32'h0000_3000);
        fetch(32'h1000_0002, 1, 32'h0000_3004);
        pcwr("bne_fwd", 2'b00, 2'b11, 32'd0, 32'h0000_300C);

        pcwr("jr_3000b", 2'b11, 2'b00, 32'h0000_3000, 32'h0000_3000);
        fetch(32'h0800_0C40, 0, 32'h0000_3004);
        pcwr("j_over_branch", 2'b01, 2'b01, 32'd0, 32'h0000_3100);
        pcwr("jal", 2'b10, 2'b00, 32'd0, 32'h0000_3100);
        pcwr("jr_misaligned", 2'b11, 2'b00, 32'h0000_3006, 32'h0000_3004);
        check("align_set", 32'(align_err), 32'd1);

        // PC wraparound
        pcwr("jr_top", 2'b11, 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check("pc_plus4_wrap", pc_plus4, 32'd0);
        pcwr("pc_wrap", 2'b00, 2'b00, 32'd0, 32'd0);
        check("align_sticky", 32'(align_err), 32'd1);

        // Timeout with pc_wr held during FETCH (must be ignored)
        ir_wr = 1'b1;
        tick();
        ir_wr   = 1'b0;
        pc_wr   = 1'b1;
        jump    = 2'b11;
        rs_data = 32'h1234_0000;
        #1;
        cyc = 0;
        while (imem_req && cyc < 40) begin
            check("to_stall", 32'(stall), (cyc == 15) ? 32'd0 : 32'd1);
            tick();
            cyc++;
        end
        pc_wr   = 1'b0;
        jump    = 2'b00;
        rs_data = 32'd0;
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_ir", ir, 32'd0);
        check("to_pc", pc, 32'h0000_0004);
        check("to_fetch_err", 32'(fetch_err), 32'd1);
        check("to_stall_idle", 32'(stall), 32'd0);

        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("late_ack_ir", ir, 32'd0);
        check("late_ack_pc", pc, 32'h0000_0004);

        // Reset in the middle of a fetch
        ir_wr = 1'b1;
        tick();
        ir_wr = 1'b0;
        check("mid_req", 32'(imem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, 32'h0000_3000);
        check("mid_rst_ferr", 32'(fetch_err), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        tick();
        rst = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("post_rst_ir", ir, 32'd0);
        check("post_rst_pc", pc, 32'h0000_3000);
        check("post_rst_req", 32'(imem_req), 32'd0);

        fetch(32'hAABB_CCDD, 2, 32'h0000_3004);
        check("sb_empty", 32'(exp_ir_q.size() + exp_pc_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
